// File: rtl/rat_solver_pkg.sv
// Shared definitions for the maze solver: FSM state encoding, direction
// codes, default goal/stack sizing, and the coordinate step helper.
package rat_solver_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PROBE = 3'd2,
    S_MARK  = 3'd3,
    S_POP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;  // Y-1
  localparam logic [1:0] DIR_RIGHT = 2'd1;  // X+1
  localparam logic [1:0] DIR_LEFT  = 2'd2;  // X-1
  localparam logic [1:0] DIR_DOWN  = 2'd3;  // Y+1

  localparam int DEF_GOAL_X = 15;
  localparam int DEF_GOAL_Y = 15;
  localparam int DEF_DEPTH  = 256;

  // Move (x,y) one cell in direction d, or against it when back=1.
  // 5-bit wrap is intentional: 0-1 = 31 and 15+1 = 16 both land outside
  // the 16x16 map, so the memory reports them as blocked.
  // Result packed as {x, y}.
  function automatic logic [9:0] step_xy(input logic [4:0] x,
                                         input logic [4:0] y,
                                         input logic [1:0] d,
                                         input logic       back);
    logic [4:0] dx;
    logic [4:0] dy;
    dx = 5'd0;
    dy = 5'd0;
    case (d)
      DIR_UP:    dy = 5'h1F;
      DIR_RIGHT: dx = 5'd1;
      DIR_LEFT:  dx = 5'h1F;
      default:   dy = 5'd1;
    endcase
    if (back) begin
      dx = 5'd0 - dx;
      dy = 5'd0 - dy;
    end
    return {x + dx, y + dy};
  endfunction

endpackage

// File: rtl/rat_solver_dir_stack.sv
// dir_stack: DEPTH x 2-bit LIFO holding the move history of the search.
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties the stack)
//   clr         synchronous empty, used when a new solve is launched
//   push, din   push din (ignored when full)
//   pop         drop the top entry (ignored when empty)
//   dout        current top entry (combinational)
//   sp          entry count; entries live at 0..sp-1 in push order
//   rd_idx      random read index, rd_dir its entry (combinational)
module dir_stack #(
  parameter int DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [1:0]                   din,
  output logic [1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic [1:0]                   rd_dir
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  logic [1:0]     mem [DEPTH];
  logic [SPW-1:0] sp_q;
  logic           full;
  logic           empty;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  wr_idx;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = IW'(sp_q - SPW'(1));
  assign wr_idx  = IW'(sp_q);

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  assign sp     = sp_q;
  assign dout   = mem[top_idx];
  assign rd_dir = mem[rd_idx];

endmodule

// File: rtl/rat_solver.sv
// rat_solver: depth-first maze solver with backtracking over a 16x16 maze
// memory, start (0,0), goal (GOAL_X,GOAL_Y). The path found is streamed out
// as 2-bit moves in the order they were taken.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               launch a solve (seen in IDLE, DONE, FAIL)
//   Dout                memory read result, 1 = wall/visited/out of bounds
//   Xm, Ym, RD, WR, Din memory coordinate / read / write port
//   readMap             one-cycle map load request
//   done, fail          result flags
//   path_valid/dir/last, path_ready   path stream
//   dbg_state           current FSM state
//
// Path stream handshake: an entry transfers on a rising edge where
// path_valid and path_ready are both 1. While path_valid is 1 and
// path_ready is 0, path_dir and path_last hold. path_valid never waits on
// path_ready, and drops once the last entry (path_last = 1) has transferred.
module rat_solver
  import rat_solver_pkg::*;
#(
  parameter int GOAL_X = DEF_GOAL_X,
  parameter int GOAL_Y = DEF_GOAL_Y,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Dout,
  output logic [4:0] Xm,
  output logic [4:0] Ym,
  output logic       RD,
  output logic       WR,
  output logic       Din,
  output logic       readMap,
  output logic       done,
  output logic       fail,
  output logic       path_valid,
  output logic [1:0] path_dir,
  output logic       path_last,
  input  logic       path_ready,
  output state_t     dbg_state
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  state_t         state, state_n;
  logic [4:0]     pos_x, pos_y, pos_x_n, pos_y_n;
  logic [1:0]     dir, dir_n;
  logic [SPW-1:0] rd_ptr, rd_ptr_n;

  logic           stk_clr, stk_push, stk_pop;
  logic [1:0]     stk_top;
  logic [SPW-1:0] sp;
  logic [IW-1:0]  rd_idx;
  logic [1:0]     rd_dir;

  logic [9:0]     cand;
  logic [9:0]     back;
  logic           at_goal;
  logic           launch;

  assign cand    = step_xy(pos_x, pos_y, dir, 1'b0);
  assign back    = step_xy(pos_x, pos_y, stk_top, 1'b1);
  assign at_goal = (pos_x == 5'(GOAL_X)) && (pos_y == 5'(GOAL_Y));
  assign rd_idx  = IW'(rd_ptr);

  dir_stack #(.DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .clr    (stk_clr),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (dir),
    .dout   (stk_top),
    .sp     (sp),
    .rd_idx (rd_idx),
    .rd_dir (rd_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pos_x  <= 5'd0;
      pos_y  <= 5'd0;
      dir    <= 2'd0;
      rd_ptr <= '0;
    end else begin
      state  <= state_n;
      pos_x  <= pos_x_n;
      pos_y  <= pos_y_n;
      dir    <= dir_n;
      rd_ptr <= rd_ptr_n;
    end
  end

  always_comb begin
    state_n    = state;
    pos_x_n    = pos_x;
    pos_y_n    = pos_y;
    dir_n      = dir;
    rd_ptr_n   = rd_ptr;
    stk_clr    = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    launch     = 1'b0;
    Xm         = 5'd0;
    Ym         = 5'd0;
    RD         = 1'b0;
    WR         = 1'b0;
    Din        = 1'b0;
    readMap    = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    path_valid = 1'b0;
    path_dir   = 2'd0;
    path_last  = 1'b0;

    case (state)
      S_IDLE: begin
        launch = start;
      end

      S_LOAD: begin
        readMap = 1'b1;
        state_n = S_PROBE;
      end

      S_PROBE: begin
        Xm = cand[9:5];
        Ym = cand[4:0];
        RD = 1'b1;
        if (!Dout) begin
          pos_x_n  = cand[9:5];
          pos_y_n  = cand[4:0];
          stk_push = 1'b1;
          state_n  = S_MARK;
        end else if (dir != DIR_DOWN) begin
          dir_n = dir + 2'd1;
        end else if (sp != '0) begin
          state_n = S_POP;
        end else begin
          state_n = S_FAIL;
        end
      end

      S_MARK: begin
        Xm  = pos_x;
        Ym  = pos_y;
        WR  = 1'b1;
        Din = 1'b1;
        if (at_goal) begin
          state_n = S_DONE;
        end else begin
          dir_n   = DIR_UP;
          state_n = S_PROBE;
        end
      end

      S_POP: begin
        // Undo the top move and resume probing at the direction after it.
        // A popped DOWN has no next direction from that cell, so the pop
        // cascades one cell further back.
        stk_pop = 1'b1;
        pos_x_n = back[9:5];
        pos_y_n = back[4:0];
        dir_n   = stk_top + 2'd1;
        if (stk_top != DIR_DOWN) begin
          state_n = S_PROBE;
        end else if (sp == SPW'(1)) begin
          state_n = S_FAIL;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        path_valid = (rd_ptr < sp);
        path_dir   = rd_dir;
        path_last  = path_valid && (rd_ptr == sp - SPW'(1));
        if (path_valid && path_ready) begin
          rd_ptr_n = rd_ptr + SPW'(1);
        end
        launch = start;
      end

      S_FAIL: begin
        fail   = 1'b1;
        launch = start;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Every launch, from any resting state, starts from a clean search.
    if (launch) begin
      state_n  = S_LOAD;
      pos_x_n  = 5'd0;
      pos_y_n  = 5'd0;
      dir_n    = DIR_UP;
      rd_ptr_n = '0;
      stk_clr  = 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rat_solver.sv
module tb_rat_solver;
  import rat_solver_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       Dout;
  logic [4:0] Xm, Ym;
  logic       RD, WR, Din, readMap, done, fail;
  logic       path_valid, path_last;
  logic [1:0] path_dir;
  logic       path_ready = 1'b0;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {path_last, path_dir}.
  logic [2:0] exp_q[$];

  // Maze memory model: wall map set by the tests, visited bits set by
  // readMap (only (0,0)) and by WR.
  logic [15:0] wall    [16];
  logic [15:0] visited [16];

  int excl_viol = 0;
  int wr_count  = 0;
  int rm_count  = 0;

  rat_solver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .Dout       (Dout),
    .Xm         (Xm),
    .Ym         (Ym),
    .RD         (RD),
    .WR         (WR),
    .Din        (Din),
    .readMap    (readMap),
    .done       (done),
    .fail       (fail),
    .path_valid (path_valid),
    .path_dir   (path_dir),
    .path_last  (path_last),
    .path_ready (path_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model and monitors ----------------
  assign Dout = (Xm > 5'd15 || Ym > 5'd15) ? 1'b1 :
                (wall[Ym[3:0]][Xm[3:0]] | visited[Ym[3:0]][Xm[3:0]]);

  always @(posedge clk) begin
    if (readMap) begin
      for (int y = 0; y < 16; y++) visited[y] <= (y == 0) ? 16'h0001 : 16'h0000;
    end else if (WR && Din && Xm < 5'd16 && Ym < 5'd16) begin
      visited[Ym[3:0]][Xm[3:0]] <= 1'b1;
    end
    if ((int'(RD) + int'(WR) + int'(readMap)) > 1) excl_viol <= excl_viol + 1;
    if (WR) wr_count <= wr_count + 1;
    if (readMap) rm_count <= rm_count + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic set_empty_maze();
    for (int y = 0; y < 16; y++) wall[y] = 16'h0000;
  endtask

  // Corridor with a dead end: (0,0)->(1,0)->(1,1)=branch; dead end
  // (2,1),(2,2),(2,3); exit (0,1) down column 0, then along row 15.
  task automatic set_deadend_maze();
    for (int y = 0; y < 16; y++) wall[y] = 16'hFFFF;
    wall[0][0] = 1'b0; wall[0][1] = 1'b0;
    wall[1][1] = 1'b0; wall[1][2] = 1'b0; wall[1][0] = 1'b0;
    wall[2][2] = 1'b0; wall[3][2] = 1'b0;
    for (int y = 2; y < 16; y++) wall[y][0] = 1'b0;
    for (int x = 1; x < 16; x++) wall[15][x] = 1'b0;
  endtask

  task automatic push_serpentine();
    logic [1:0] d;
    exp_q.delete();
    for (int r = 0; r < 15; r++) begin
      d = ((r % 2) == 0) ? DIR_RIGHT : DIR_LEFT;
      for (int c = 0; c < 15; c++) exp_q.push_back({1'b0, d});
      exp_q.push_back({(r == 14), DIR_DOWN});
    end
  endtask

  task automatic push_deadend_path();
    exp_q.delete();
    exp_q.push_back({1'b0, DIR_RIGHT});
    exp_q.push_back({1'b0, DIR_DOWN});
    exp_q.push_back({1'b0, DIR_LEFT});
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, DIR_DOWN});
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, DIR_RIGHT});
    exp_q.push_back({1'b1, DIR_RIGHT});
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!done && !fail && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL %s_solve: done=%0b fail=%0b after %0d cycles, want done=1 fail=0",
               name, done, fail, n);
    end
  endtask

  // Scoreboard drain. mode 0: ready always 1; 1: random ready;
  // 2: ready pattern 1,0,0,1 then random.
  task automatic drain_stream(input string name, input int mode);
    int budget;
    int step;
    int total;
    int xfers;
    logic [3:0] pat;
    logic [2:0] seen;
    budget = 3000;
    step   = 0;
    xfers  = 0;
    total  = exp_q.size();
    pat    = 4'b1001;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (mode == 0) path_ready = 1'b1;
      else if (mode == 2 && step < 4) path_ready = pat[3 - step];
      else path_ready = 1'($urandom_range(0, 1));
      step++;
      seen = {path_last, path_dir};
      checks++;
      if (path_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid: path_valid=%0b with %0d entries left, want 1",
                 name, path_valid, exp_q.size());
        break;
      end else if (seen !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_entry%0d: got last=%0b dir=%0d, want last=%0b dir=%0d (ready=%0b)",
                 name, xfers, seen[2], seen[1:0], exp_q[0][2], exp_q[0][1:0], path_ready);
      end
      if (path_ready) begin
        void'(exp_q.pop_front());
        xfers++;
      end
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL %s_timeout: stream incomplete, %0d entries left", name, exp_q.size());
    end
    @(negedge clk);
    path_ready = 1'b0;
    checks++;
    if (path_valid !== 1'b0 || done !== 1'b1 || xfers != total) begin
      errors++;
      $display("FAIL %s_end: path_valid=%0b done=%0b xfers=%0d, want 0 1 %0d",
               name, path_valid, done, xfers, total);
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want %0d", dbg_state, S_IDLE);
    end
    checks++;
    if ({Xm, Ym, RD, WR, Din, readMap, done, fail, path_valid, path_last} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got Xm=%0d Ym=%0d RD=%0b WR=%0b Din=%0b rm=%0b done=%0b fail=%0b pv=%0b pl=%0b, want all 0",
               Xm, Ym, RD, WR, Din, readMap, done, fail, path_valid, path_last);
    end
  endtask

  task automatic test_empty_maze();
    set_empty_maze();
    push_serpentine();
    pulse_start();
    wait_end("empty", 4000);
    drain_stream("empty", 0);
  endtask

  task automatic test_boxed();
    int wr_before;
    set_empty_maze();
    wall[0][1] = 1'b1;
    wall[1][0] = 1'b1;
    wr_before = wr_count;
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (fail !== (k == 5)) begin
        errors++;
        $display("FAIL boxed_fail_edge%0d: fail=%0b, want %0b", k, fail, (k == 5));
      end
    end
    checks++;
    if (wr_count != wr_before || done !== 1'b0) begin
      errors++;
      $display("FAIL boxed_wr: WR cycles=%0d done=%0b, want 0 0", wr_count - wr_before, done);
    end
  endtask

  task automatic test_deadend();
    int n;
    int pop_run;
    bit seen_backtrack;
    set_deadend_maze();
    push_deadend_path();
    pulse_start();
    n = 0;
    pop_run = 0;
    seen_backtrack = 1'b0;
    while (!done && !fail && n < 2000) begin
      @(negedge clk);
      n++;
      if (dbg_state == S_POP) begin
        pop_run++;
      end else begin
        if (pop_run > 0 && !seen_backtrack) begin
          seen_backtrack = 1'b1;
          checks++;
          if (pop_run != 3) begin
            errors++;
            $display("FAIL deadend_pop_run: got %0d POP cycles, want 3", pop_run);
          end
          checks++;
          if (dbg_state !== S_PROBE || Xm !== 5'd0 || Ym !== 5'd1) begin
            errors++;
            $display("FAIL deadend_resume: state=%0d probe=(%0d,%0d), want state=%0d probe=(0,1)",
                     dbg_state, Xm, Ym, S_PROBE);
          end
        end
        pop_run = 0;
      end
    end
    checks++;
    if (!seen_backtrack) begin
      errors++;
      $display("FAIL deadend_backtrack: saw no POP cycles, want 3");
    end
    wait_end("deadend", 10);
  endtask

  task automatic test_backpressure();
    drain_stream("backpressure", 2);
  endtask

  task automatic test_reset_mid_probe();
    int n;
    set_empty_maze();
    pulse_start();
    n = 0;
    repeat (7) @(negedge clk);
    while (dbg_state != S_PROBE && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE ||
        {Xm, Ym, RD, WR, Din, readMap, done, fail, path_valid, path_last} !== 20'd0) begin
      errors++;
      $display("FAIL midreset: state=%0d Xm=%0d Ym=%0d RD=%0b WR=%0b done=%0b fail=%0b pv=%0b, want IDLE and all 0",
               dbg_state, Xm, Ym, RD, WR, done, fail, path_valid);
    end
    push_serpentine();
    pulse_start();
    wait_end("after_reset", 4000);
    drain_stream("after_reset", 1);
  endtask

  task automatic test_start_ignored();
    int n;
    set_deadend_maze();
    push_deadend_path();
    pulse_start();
    n = 0;
    repeat (3) @(negedge clk);
    while (dbg_state != S_PROBE && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("start_ignored", 2000);
    drain_stream("start_ignored", 1);
  endtask

  task automatic test_back_to_back();
    int rm_before;
    set_empty_maze();
    push_serpentine();
    rm_before = rm_count;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_end("back_to_back", 4000);
    checks++;
    if (rm_count - rm_before != 1) begin
      errors++;
      $display("FAIL back_to_back_launch: readMap pulses=%0d, want 1", rm_count - rm_before);
    end
    drain_stream("back_to_back", 1);
    checks++;
    if (excl_viol != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: %0d cycles with RD/WR/readMap overlap, want 0", excl_viol);
    end
  endtask

  initial begin
    for (int y = 0; y < 16; y++) begin
      wall[y] = 16'h0000;
    end
    test_reset();
    test_empty_maze();
    test_boxed();
    test_deadend();
    test_backpressure();
    test_reset_mid_probe();
    test_start_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
